// File: rtl/xor_parity_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xor_parity_pkg
// Description : Shared types and constants for the parity-checked serial
//               receiver: receiver FSM state encoding and the number of
//               non-payload bits carried by every frame.
// Revision    : 1.0 - initial release
// ============================================================================
package xor_parity_pkg;

    // Receiver FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    // Start + parity + stop bits surrounding the payload.
    localparam int unsigned FRAME_OVERHEAD = 3;

endpackage : xor_parity_pkg
`default_nettype wire

// File: rtl/xor_parity_acc.sv
`default_nettype none
// ============================================================================
// Module      : xor_parity_acc
// Description : 1-bit running XOR accumulator with synchronous clear to a
//               configurable seed value.
// Ports       : clk   - system clock
//               rst_n - asynchronous active-low reset (q -> 0)
//               clr   - load CLEAR_VAL (has priority over en)
//               en    - fold d into the accumulator
//               d     - data bit
//               q     - accumulated parity
// Revision    : 1.0 - initial release
// ============================================================================
module xor_parity_acc #(
    parameter logic CLEAR_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (clr) begin
            q <= CLEAR_VAL;
        end else if (en) begin
            q <= q ^ d;
        end
    end

endmodule : xor_parity_acc
`default_nettype wire

// File: rtl/xor_parity_rx.sv
`default_nettype none
// ============================================================================
// Module      : xor_parity_rx
// Description : Strobed serial frame receiver. Frame = start(0), DATA_W data
//               bits LSB first, parity bit, stop(1). Reports the payload with
//               parity and framing error flags on a one-cycle VALID pulse.
// Ports       : clk      - system clock, rising edge
//               rst_n    - asynchronous active-low reset
//               bit_en   - bit strobe; ser_in sampled only when high
//               ser_in   - serial line, idles high
//               data_out - last received payload (held until next valid)
//               valid    - one-cycle frame-complete pulse
//               par_err  - parity mismatch, qualified by valid
//               frm_err  - stop bit was 0, qualified by valid
//               busy     - receiver is inside a frame
// Revision    : 1.0 - initial release
// ============================================================================
module xor_parity_rx
    import xor_parity_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              ser_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              par_err,
    output logic              frm_err,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(DATA_W - 1);
    localparam logic c_acc_seed = (PARITY_ODD != 0);

    rx_state_e          r_state;
    rx_state_e          w_state_next;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]   w_bit_cnt_next;
    logic [DATA_W-1:0]  r_shift;
    logic               r_par_pend;

    logic               w_acc_clr;
    logic               w_acc_en;
    logic               w_acc_q;
    logic               w_shift_en;
    logic               w_par_capture;
    logic               w_deliver;

    // ------------------------------------------------------------------------
    // Running parity accumulator
    // ------------------------------------------------------------------------
    xor_parity_acc #(
        .CLEAR_VAL (c_acc_seed)
    ) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_acc_clr),
        .en    (w_acc_en),
        .d     (ser_in),
        .q     (w_acc_q)
    );

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_acc_clr      = 1'b0;
        w_acc_en       = 1'b0;
        w_shift_en     = 1'b0;
        w_par_capture  = 1'b0;
        w_deliver      = 1'b0;

        if (bit_en) begin
            case (r_state)
                IDLE: begin
                    if (!ser_in) begin
                        w_state_next   = DATA;
                        w_bit_cnt_next = '0;
                        w_acc_clr      = 1'b1;
                    end
                end
                DATA: begin
                    w_shift_en     = 1'b1;
                    w_acc_en       = 1'b1;
                    w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
                    if (r_bit_cnt == c_last_bit) begin
                        w_state_next = PARITY;
                    end
                end
                PARITY: begin
                    w_par_capture = 1'b1;
                    w_state_next  = STOP;
                end
                STOP: begin
                    // Always return to IDLE, even on a 0 stop bit: a broken
                    // stop bit is never reinterpreted as the next start bit.
                    w_deliver    = 1'b1;
                    w_state_next = IDLE;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Payload shift register and parity result holding
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_par_pend <= 1'b0;
        end else begin
            // LSB arrives first, so shifting right lands it in bit 0.
            if (w_shift_en) begin
                r_shift <= {ser_in, r_shift[DATA_W-1:1]};
            end
            // Parity verdict is held until the stop bit completes the frame.
            if (w_par_capture) begin
                r_par_pend <= w_acc_q ^ ser_in;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            valid    <= 1'b0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            valid <= w_deliver;
            if (w_deliver) begin
                data_out <= r_shift;
                par_err  <= r_par_pend;
                frm_err  <= ~ser_in;
            end
        end
    end

    assign busy = (r_state != IDLE);

endmodule : xor_parity_rx
`default_nettype wire

// File: tb/tb_xor_parity_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_xor_parity_rx
// Description : Directed self-checking bench for xor_parity_rx. Instantiates
//               an even-parity and an odd-parity receiver on shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xor_parity_rx;

    logic       clk;
    logic       rst_n;
    logic       bit_en;
    logic       ser_in;

    logic [7:0] data_out;
    logic       valid;
    logic       par_err;
    logic       frm_err;
    logic       busy;

    logic [7:0] o_data_out;
    logic       o_valid;
    logic       o_par_err;
    logic       o_frm_err;
    logic       o_busy;

    int errors = 0;
    int checks = 0;
    int vcnt   = 0;
    int run    = 0;
    int maxrun = 0;

    xor_parity_rx #(.DATA_W(8), .PARITY_ODD(0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bit_en   (bit_en),
        .ser_in   (ser_in),
        .data_out (data_out),
        .valid    (valid),
        .par_err  (par_err),
        .frm_err  (frm_err),
        .busy     (busy)
    );

    xor_parity_rx #(.DATA_W(8), .PARITY_ODD(1)) dut_odd (
        .clk      (clk),
        .rst_n    (rst_n),
        .bit_en   (bit_en),
        .ser_in   (ser_in),
        .data_out (o_data_out),
        .valid    (o_valid),
        .par_err  (o_par_err),
        .frm_err  (o_frm_err),
        .busy     (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Valid pulse counter and pulse-width tracker for the even receiver.
    always @(negedge clk) begin
        if (valid) begin
            vcnt = vcnt + 1;
            run  = run + 1;
            if (run > maxrun) maxrun = run;
        end else begin
            run = 0;
        end
    end

    // gap idle cycles, then one strobe cycle; returns 1 time unit after the
    // edge that sampled the bit.
    task automatic strobe(input logic b, input int gap);
        for (int i = 0; i < gap; i++) begin
            bit_en = 1'b0;
            @(posedge clk); #1;
        end
        ser_in = b;
        bit_en = 1'b1;
        @(posedge clk); #1;
        bit_en = 1'b0;
        ser_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par,
                              input logic stp, input int gap);
        strobe(1'b0, gap);
        for (int i = 0; i < 8; i++) strobe(d[i], gap);
        strobe(par, gap);
        strobe(stp, gap);
    endtask

    task automatic test_reset();
        bit_en = 1'b0;
        ser_in = 1'b1;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data_out); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL reset_par got=%b exp=0", par_err); end
        checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL reset_frm got=%b exp=0", frm_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_good_frame();
        int v0;
        v0 = vcnt;
        strobe(1'b0, 0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_busy_after_start got=%b exp=1", busy); end
        for (int i = 0; i < 8; i++) strobe(((8'hA5 >> i) & 8'h01) != 0, 0);
        strobe(1'b0, 0);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL good_valid_early got=%b exp=0", valid); end
        strobe(1'b1, 0);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL good_valid got=%b exp=1", valid); end
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL good_data got=%h exp=a5", data_out); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL good_par got=%b exp=0", par_err); end
        checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL good_frm got=%b exp=0", frm_err); end
        @(posedge clk); #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL good_valid_width got=%b exp=0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy_end got=%b exp=0", busy); end
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL good_data_hold got=%h exp=a5", data_out); end
        checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL good_valid_count got=%0d exp=1", vcnt - v0); end
    endtask

    task automatic test_par_err();
        send_frame(8'h01, 1'b0, 1'b1, 0);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL par_valid got=%b exp=1", valid); end
        checks++; if (data_out !== 8'h01) begin errors++; $display("FAIL par_data got=%h exp=01", data_out); end
        checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL par_err got=%b exp=1", par_err); end
        checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL par_frm got=%b exp=0", frm_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_frm_err();
        int v0;
        send_frame(8'hFF, 1'b0, 1'b0, 0);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL frm_valid got=%b exp=1", valid); end
        checks++; if (data_out !== 8'hFF) begin errors++; $display("FAIL frm_data got=%h exp=ff", data_out); end
        checks++; if (frm_err !== 1'b1) begin errors++; $display("FAIL frm_err got=%b exp=1", frm_err); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL frm_par got=%b exp=0", par_err); end
        @(posedge clk); #1;
        v0 = vcnt;
        for (int i = 0; i < 20; i++) strobe(1'b1, 0);
        @(posedge clk); #1;
        checks++; if (vcnt - v0 !== 0) begin errors++; $display("FAIL frm_idle_valids got=%0d exp=0", vcnt - v0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frm_idle_busy got=%b exp=0", busy); end
        checks++; if (frm_err !== 1'b1) begin errors++; $display("FAIL frm_hold got=%b exp=1", frm_err); end
    endtask

    task automatic test_back_to_back();
        int v0;
        v0     = vcnt;
        maxrun = 0;
        send_frame(8'h3C, 1'b0, 1'b1, 3);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1 got=%b exp=1", valid); end
        checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL b2b_data1 got=%h exp=3c", data_out); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL b2b_par1 got=%b exp=0", par_err); end
        send_frame(8'hC3, 1'b0, 1'b1, 3);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_valid2 got=%b exp=1", valid); end
        checks++; if (data_out !== 8'hC3) begin errors++; $display("FAIL b2b_data2 got=%h exp=c3", data_out); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL b2b_par2 got=%b exp=0", par_err); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (vcnt - v0 !== 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", vcnt - v0); end
        checks++; if (maxrun !== 1) begin errors++; $display("FAIL b2b_width got=%0d exp=1", maxrun); end
    endtask

    task automatic test_reset_mid();
        int v0;
        v0 = vcnt;
        strobe(1'b0, 0);
        for (int i = 0; i < 5; i++) strobe(((8'h55 >> i) & 8'h01) != 0, 0);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rstmid_data got=%h exp=00", data_out); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL rstmid_par got=%b exp=0", par_err); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        // Remaining bits of the abandoned frame are idle-high line here.
        for (int i = 0; i < 5; i++) strobe(1'b1, 0);
        checks++; if (vcnt - v0 !== 0) begin errors++; $display("FAIL rstmid_novalid got=%0d exp=0", vcnt - v0); end
        send_frame(8'h12, 1'b0, 1'b1, 0);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rstmid_valid got=%b exp=1", valid); end
        checks++; if (data_out !== 8'h12) begin errors++; $display("FAIL rstmid_data2 got=%h exp=12", data_out); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL rstmid_par2 got=%b exp=0", par_err); end
        checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL rstmid_frm2 got=%b exp=0", frm_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_odd_parity();
        send_frame(8'h00, 1'b1, 1'b1, 0);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL odd_valid1 got=%b exp=1", o_valid); end
        checks++; if (o_par_err !== 1'b0) begin errors++; $display("FAIL odd_par1 got=%b exp=0", o_par_err); end
        checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL odd_even_view got=%b exp=1", par_err); end
        @(posedge clk); #1;
        send_frame(8'h00, 1'b0, 1'b1, 0);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL odd_valid2 got=%b exp=1", o_valid); end
        checks++; if (o_par_err !== 1'b1) begin errors++; $display("FAIL odd_par2 got=%b exp=1", o_par_err); end
        checks++; if (o_data_out !== 8'h00) begin errors++; $display("FAIL odd_data got=%h exp=00", o_data_out); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        bit_en = 1'b0;
        ser_in = 1'b1;
        test_reset();
        test_good_frame();
        test_par_err();
        test_frm_err();
        test_back_to_back();
        test_reset_mid();
        test_odd_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_xor_parity_rx
`default_nettype wire
